// File: rtl/pic_priority_ctrl_if.sv
// pic_priority_ctrl_if
//   Bundles the request lines, the decoded front-end strobes, the CPU
//   acknowledge and the controller outputs of pic_priority_ctrl.
//   master : request/front-end/CPU side (drives irq, cfg_*, mask_*, eoi_*, inta_n)
//   slave  : the priority controller (drives int_out, vector_*, *_out readback)
interface pic_priority_ctrl_if #(
    parameter int NUM_IRQ  = 8,
    parameter int ID_W     = $clog2(NUM_IRQ),
    parameter int VECTOR_W = 8
);
    logic [NUM_IRQ-1:0]       irq;
    logic                     cfg_write;
    logic                     cfg_level;
    logic                     cfg_aeoi;
    logic                     cfg_rotate;
    logic [VECTOR_W-ID_W-1:0] cfg_base;
    logic                     mask_write;
    logic [NUM_IRQ-1:0]       mask_data;
    logic                     eoi_valid;
    logic [2:0]               eoi_cmd;
    logic [ID_W-1:0]          eoi_level;
    logic                     inta_n;
    logic                     int_out;
    logic [VECTOR_W-1:0]      vector_out;
    logic                     vector_valid;
    logic [NUM_IRQ-1:0]       irr_out;
    logic [NUM_IRQ-1:0]       isr_out;
    logic [NUM_IRQ-1:0]       imr_out;

    modport master (
        output irq, cfg_write, cfg_level, cfg_aeoi, cfg_rotate, cfg_base,
               mask_write, mask_data, eoi_valid, eoi_cmd, eoi_level, inta_n,
        input  int_out, vector_out, vector_valid, irr_out, isr_out, imr_out
    );

    modport slave (
        input  irq, cfg_write, cfg_level, cfg_aeoi, cfg_rotate, cfg_base,
               mask_write, mask_data, eoi_valid, eoi_cmd, eoi_level, inta_n,
        output int_out, vector_out, vector_valid, irr_out, isr_out, imr_out
    );
endinterface

// File: rtl/pic_priority_ctrl.sv
// pic_priority_ctrl
//   8259-style interrupt priority controller: IRR/IMR/ISR registers, rotating
//   priority resolver, CPU interrupt line and the two-pulse INTA sequence that
//   returns vector {base, id}.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : pic_priority_ctrl_if.slave (irq, cfg_*, mask_*, eoi_*, inta_n in;
//              int_out, vector_out, vector_valid, irr/isr/imr_out out)
// Optional feature: define PIC_AUTO_ROTATE_EN to make an AEOI-completed ack
// also rotate the served line to lowest priority when cfg_rotate was set.
module pic_priority_ctrl #(
    parameter int NUM_IRQ  = 8,
    parameter int ID_W     = $clog2(NUM_IRQ),
    parameter int VECTOR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    pic_priority_ctrl_if.slave bus
);
    localparam int BASE_W = VECTOR_W - ID_W;

    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_ACK2, S_VEC} state_t;

    state_t              state, state_next;
    logic [NUM_IRQ-1:0]  irr, isr, imr, irq_prev;
    logic [NUM_IRQ-1:0]  irr_next, isr_next, ack_set, eoi_clr, aeoi_clr;
    logic [ID_W-1:0]     lptr, l_next;
    logic                level_mode, aeoi_mode;
    logic [BASE_W-1:0]   base;
    logic [ID_W-1:0]     w_id, ack_id;
    logic                w_spur;
    logic                int_q, int_next;
    logic                inta_q1, inta_q2, inta_fall, inta_rise;
    logic                ack_take, vec_done;

`ifdef PIC_AUTO_ROTATE_EN
    logic                rotate_mode;
`else
    logic                unused_rotate;
    assign unused_rotate = bus.cfg_rotate;
`endif

    // Scan priority ranks from highest (l+1) to lowest (l). Returns {found, id}.
    // Power-of-two NUM_IRQ lets the wrap happen in ID_W-bit arithmetic.
    function automatic logic [ID_W:0] prio_scan(input logic [NUM_IRQ-1:0] v,
                                                input logic [ID_W-1:0]    l);
        logic [ID_W:0]   r;
        logic [ID_W-1:0] idx;
        r = '0;
        for (int k = NUM_IRQ-1; k >= 0; k--) begin
            idx = l + ID_W'(1) + ID_W'(k);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // ---------------- priority resolver ----------------
    logic              win_found, isr_found;
    logic [ID_W-1:0]   win_id, isr_top, win_rank, isr_rank;

    always_comb begin
        {win_found, win_id} = prio_scan(irr & ~imr, lptr);
        {isr_found, isr_top} = prio_scan(isr, lptr);
        // rank 0 = highest priority
        win_rank = win_id - lptr - ID_W'(1);
        isr_rank = isr_top - lptr - ID_W'(1);
        int_next = win_found && (!isr_found || (win_rank < isr_rank));
        ack_id   = win_found ? win_id : ID_W'(NUM_IRQ-1);
    end

    // ---------------- INTA edge detect ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            inta_q1 <= 1'b1;
            inta_q2 <= 1'b1;
        end else begin
            inta_q1 <= bus.inta_n;
            inta_q2 <= inta_q1;
        end
    end

    assign inta_fall = inta_q2 & ~inta_q1;
    assign inta_rise = ~inta_q2 & inta_q1;

    // ---------------- ack FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!reset_n || bus.cfg_write) state <= S_IDLE;
        else                           state <= state_next;
    end

    // ---------------- ack FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (inta_fall) state_next = S_ACK1;
            S_ACK1: if (inta_rise) state_next = S_ACK2;
            S_ACK2: if (inta_fall) state_next = S_VEC;
            S_VEC:  if (inta_rise) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- ack FSM: outputs ----------------
    always_comb begin
        ack_take         = (state == S_IDLE) && inta_fall;
        vec_done         = (state == S_VEC) && inta_rise;
        bus.vector_valid = (state == S_VEC);
        bus.vector_out   = (state == S_VEC) ? {base, w_id} : '0;
    end

    // ---------------- register next-values ----------------
    always_comb begin
        ack_set  = (ack_take && win_found) ? (NUM_IRQ'(1) << win_id) : '0;
        aeoi_clr = (vec_done && aeoi_mode && !w_spur) ? (NUM_IRQ'(1) << w_id) : '0;
        eoi_clr  = '0;
        l_next   = lptr;
`ifdef PIC_AUTO_ROTATE_EN
        if (vec_done && aeoi_mode && rotate_mode && !w_spur) l_next = w_id;
`endif
        // Explicit EOI commands override the automatic rotation on a collision.
        if (bus.eoi_valid) begin
            case (bus.eoi_cmd)
                3'b001: if (isr_found) eoi_clr = NUM_IRQ'(1) << isr_top;
                3'b011: eoi_clr = NUM_IRQ'(1) << bus.eoi_level;
                3'b101: if (isr_found) begin
                            eoi_clr = NUM_IRQ'(1) << isr_top;
                            l_next  = isr_top;
                        end
                3'b111: begin
                            eoi_clr = NUM_IRQ'(1) << bus.eoi_level;
                            l_next  = bus.eoi_level;
                        end
                3'b110: l_next = bus.eoi_level;
                default: ;
            endcase
        end
        // In level mode the ack clear lasts only the ack cycle; the line
        // re-asserts IRR on the next cycle if still held.
        irr_next = (level_mode ? bus.irq : (irr | (bus.irq & ~irq_prev))) & ~ack_set;
        // An ack set beats a same-bit EOI clear.
        isr_next = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irr        <= '0;
            isr        <= '0;
            imr        <= '1;
            lptr       <= ID_W'(NUM_IRQ-1);
            level_mode <= 1'b0;
            aeoi_mode  <= 1'b0;
            base       <= '0;
            irq_prev   <= '0;
            w_id       <= '0;
            w_spur     <= 1'b0;
            int_q      <= 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
            rotate_mode <= 1'b0;
`endif
        end else if (bus.cfg_write) begin
            irr        <= '0;
            isr        <= '0;
            imr        <= '1;
            lptr       <= ID_W'(NUM_IRQ-1);
            level_mode <= bus.cfg_level;
            aeoi_mode  <= bus.cfg_aeoi;
            base       <= bus.cfg_base;
            irq_prev   <= bus.irq;
            w_id       <= '0;
            w_spur     <= 1'b0;
            int_q      <= 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
            rotate_mode <= bus.cfg_rotate;
`endif
        end else begin
            irr      <= irr_next;
            isr      <= isr_next;
            lptr     <= l_next;
            irq_prev <= bus.irq;
            int_q    <= int_next;
            // winner is resolved with the IMR value from before this edge
            if (bus.mask_write) imr <= bus.mask_data;
            if (ack_take) begin
                w_id   <= ack_id;
                w_spur <= !win_found;
            end
        end
    end

    assign bus.int_out = int_q;
    assign bus.irr_out = irr;
    assign bus.isr_out = isr;
    assign bus.imr_out = imr;

endmodule

// File: doc/pic_priority_ctrl.md
# pic_priority_ctrl

Parametrised, fully synchronous interrupt priority controller for the 8259-style PIC. It holds the IRR, IMR and ISR registers and the rotating priority resolver, drives the CPU interrupt line, and runs the two-pulse interrupt-acknowledge sequence that returns a vector. It sits between the per-line request inputs and the bus/control front end. That front end decodes ICW/OCW writes into the `cfg_*`, `mask_*` and `eoi_*` strobes defined below.

## Interface
- `NUM_IRQ`, 8: number of request lines; must be one of 2, 4, 8, 16.
- `ID_W`, `$clog2(NUM_IRQ)`: width of a line id. Derived; do not override.
- `VECTOR_W`, 8: vector width. Vector = {base, id}; base width = `VECTOR_W-ID_W`.

Ports:
- `clock`  in  1: single clock; all logic rising-edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `irq`  in  NUM_IRQ: request lines, already synchronous to `clock`.
- `cfg_write`  in  1: initialisation strobe (ICW1/ICW2 equivalent), one cycle.
- `cfg_level`  in  1: 1 = level-triggered, 0 = edge-triggered; sampled on `cfg_write`.
- `cfg_aeoi`  in  1: automatic EOI enable; sampled on `cfg_write`.
- `cfg_rotate`  in  1: automatic rotation enable; sampled on `cfg_write`. Only has an effect when the rotation macro is defined.
- `cfg_base`  in  VECTOR_W-ID_W: vector base; sampled on `cfg_write`.
- `mask_write`  in  1: IMR load strobe.
- `mask_data`  in  NUM_IRQ: new IMR; 1 = masked.
- `eoi_valid`  in  1: EOI/priority command strobe.
- `eoi_cmd`  in  3: command code, listed under Operation.
- `eoi_level`  in  ID_W: line id used by specific commands.
- `inta_n`  in  1: CPU acknowledge, active low, synchronous to `clock`.
- `int_out`  out  1: interrupt request to the CPU.
- `vector_out`  out  VECTOR_W: vector; only meaningful while `vector_valid` is high.
- `vector_valid`  out  1: high while the vector is driven.
- `irr_out`, `isr_out`, `imr_out`  out  NUM_IRQ: register readback.

## Operation
**Reset and initialisation.** Reset (`reset_n` = 0) produces:
- IRR = 0, ISR = 0, IMR = all ones.
- Lowest-priority pointer L = NUM_IRQ-1.
- `cfg_level` = `cfg_aeoi` = rotate = 0, base = 0.
- Ack FSM = IDLE; all outputs 0 except `imr_out`.

`cfg_write` performs the same clears, but loads the cfg fields from the inputs instead of zeroing them. It has priority over every other strobe in the same cycle.

**IRR.**
- Edge mode: a bit sets on a 0→1 transition of `irq[i]`, using the registered previous value. It clears when that line is acknowledged.
- Level mode: `IRR[i]` follows `irq[i]` each cycle. The acknowledge clear applies only in the acknowledge cycle.

**Priority resolution.**
- Priority order starts at (L+1) mod NUM_IRQ (highest) and ends at L (lowest).
- Eligible requests = IRR & ~IMR.
- Winner = highest-priority eligible bit.
- `int_out` is registered. It is high when a winner exists and the winner's priority is strictly higher than the highest-priority ISR bit (fully nested mode), or when ISR = 0.

**Ack FSM.** `inta_n` is registered to detect edges. States IDLE, ACK1, ACK2, VEC:
- IDLE: on a falling edge of `inta_n`:
  - Latch the winner id into W.
  - If a winner exists, set `ISR[W]` and clear `IRR[W]`.
  - If no winner exists (spurious), W = NUM_IRQ-1 and ISR is unchanged.
  - Go to ACK1.
- ACK1: on a rising edge, go to ACK2.
- ACK2: on a falling edge, go to VEC.
- VEC: drive `vector_valid` = 1 and `vector_out` = {base, W}. On a rising edge, go to IDLE. If AEOI is set and the ack was not spurious, clear `ISR[W]` in that cycle.

**EOI commands** (`eoi_valid`):
- 001 non-specific: clear the highest-priority ISR bit.
- 011 specific: clear `ISR[eoi_level]`.
- 101 rotate on non-specific: clear the highest-priority ISR bit; L = its id.
- 111 rotate on specific: clear `ISR[eoi_level]`; L = `eoi_level`.
- 110 set priority: L = `eoi_level`; ISR unchanged.
- Other codes: no-op.
- Non-specific commands with ISR = 0: no-op.

**Simultaneous events.**
- An ack set and an EOI clear on the same bit in the same cycle: the set wins. Different bits: both apply.
- `mask_write` and ack in the same cycle: the winner is computed with the old IMR.

## Timing
- `irq` edge to IRR set: 1 cycle.
- IRR/IMR/ISR change to `int_out`: 1 cycle. Worst case `irq` to `int_out` is 2 cycles.
- `inta_n` edge to FSM transition: 2 cycles (1 register stage plus 1 state update).
- `vector_valid` rises 2 cycles after the second falling edge of `inta_n`. It falls 2 cycles after the following rising edge.
- `int_out` deasserts 1 cycle after the ISR/IRR update from the first ack edge, unless a higher-priority request is pending.
- Strobes take effect on the next clock edge. Their effect on `*_out` is visible 1 cycle after the strobe.
- `reset_n` asserted mid-sequence: the next edge returns the FSM to IDLE and `vector_valid` to 0.

## Configuration
- Macro `PIC_AUTO_ROTATE_EN`.
- Defined: when rotate and AEOI are both set, the AEOI clear at the end of VEC also sets L = W, so the served line becomes lowest priority. A spurious ack leaves L unchanged.
- Undefined: `cfg_rotate` is ignored and has no storage. L changes only through EOI codes 101, 111 and 110.

## Test plan
- NUM_IRQ = 8, edge mode, IMR = 0, pulse `irq[3]`, two `inta_n` pulses, base = 5'h10 → `int_out` = 1; `ISR[3]` = 1 after the first pulse; `vector_out` = 8'h83 with `vector_valid` = 1; EOI 001 clears ISR.
- `irq[5]` and `irq[2]` both pending, reset priority → the first ack serves 2. With `ISR[2]` set, `int_out` stays 0 for 5 until EOI 011 with `eoi_level` = 2.
- No request, `inta_n` pulses → spurious vector {base, 7}; ISR stays 0.
- EOI 110 with `eoi_level` = 4, then `irq[4]` and `irq[5]` both pending → 5 is served first.
- `PIC_AUTO_ROTATE_EN` defined, AEOI + rotate, `irq[1]` and `irq[6]` held in level mode → serve order 1, 6, 1, 6; ISR = 0 after each VEC.
- `cfg_write` during ACK2 → FSM to IDLE, IMR = 8'hFF, ISR = IRR = 0, no vector driven.
